// File: rtl/bellek_islem_birimi_if.sv
// Execute, bus-unit and writeback signals of the memory stage (bellek_islem_birimi).
// Carries hata_o only when HIZASIZ_ERISIM_DENETIM_EN is defined.
interface bellek_islem_birimi_if #(
    parameter int VERI_BIT  = 32,
    parameter int ADRES_BIT = 32
);
    logic                 yurut_gecerli_i;
    logic                 yurut_hazir_o;
    logic                 yurut_yaz_i;
    logic [2:0]           yurut_tip_i;
    logic [ADRES_BIT-1:0] yurut_adres_i;
    logic [VERI_BIT-1:0]  yurut_veri_i;
    logic [4:0]           yurut_rd_i;
    logic                 bib_istek_gecerli_o;
    logic                 bib_istek_yaz_o;
    logic                 bib_istek_oku_o;
    logic [ADRES_BIT-1:0] bib_istek_adres_o;
    logic [3:0]           bib_istek_maske_o;
    logic [VERI_BIT-1:0]  bib_veri_o;
    logic [VERI_BIT-1:0]  bellek_veri_i;
    logic                 bellek_gecerli_i;
    logic                 geri_gecerli_o;
    logic                 geri_hazir_i;
    logic [VERI_BIT-1:0]  geri_veri_o;
    logic [4:0]           geri_rd_o;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
    logic                 hata_o;

    modport master (
        input  yurut_gecerli_i, yurut_yaz_i, yurut_tip_i, yurut_adres_i, yurut_veri_i,
               yurut_rd_i, bellek_veri_i, bellek_gecerli_i, geri_hazir_i,
        output yurut_hazir_o, bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
               bib_istek_adres_o, bib_istek_maske_o, bib_veri_o, geri_gecerli_o,
               geri_veri_o, geri_rd_o, hata_o
    );
    modport slave (
        output yurut_gecerli_i, yurut_yaz_i, yurut_tip_i, yurut_adres_i, yurut_veri_i,
               yurut_rd_i, bellek_veri_i, bellek_gecerli_i, geri_hazir_i,
        input  yurut_hazir_o, bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
               bib_istek_adres_o, bib_istek_maske_o, bib_veri_o, geri_gecerli_o,
               geri_veri_o, geri_rd_o, hata_o
    );
`else
    modport master (
        input  yurut_gecerli_i, yurut_yaz_i, yurut_tip_i, yurut_adres_i, yurut_veri_i,
               yurut_rd_i, bellek_veri_i, bellek_gecerli_i, geri_hazir_i,
        output yurut_hazir_o, bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
               bib_istek_adres_o, bib_istek_maske_o, bib_veri_o, geri_gecerli_o,
               geri_veri_o, geri_rd_o
    );
    modport slave (
        output yurut_gecerli_i, yurut_yaz_i, yurut_tip_i, yurut_adres_i, yurut_veri_i,
               yurut_rd_i, bellek_veri_i, bellek_gecerli_i, geri_hazir_i,
        input  yurut_hazir_o, bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
               bib_istek_adres_o, bib_istek_maske_o, bib_veri_o, geri_gecerli_o,
               geri_veri_o, geri_rd_o
    );
`endif
endinterface

// File: rtl/bellek_islem_birimi.sv
// RV32 load/store memory stage: one bus request per micro-op, load result extended for writeback.
// Optional misaligned-access trapping via HIZASIZ_ERISIM_DENETIM_EN (adds hata_o).
module bellek_islem_birimi #(
    parameter int VERI_BIT  = 32,
    parameter int ADRES_BIT = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    bellek_islem_birimi_if.master  bib
);

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] BEKLE = 2'd1;
    localparam logic [1:0] SONUC = 2'd2;

    function automatic logic [3:0] maske_hesapla(input logic [2:0] tip, input logic [1:0] ofs);
        logic [3:0] taban;
        case (tip)
            3'b000, 3'b100: taban = 4'b0001;
            3'b001, 3'b101: taban = 4'b0011;
            default:        taban = 4'b1111;
        endcase
        return taban << ofs;
    endfunction

    function automatic logic [VERI_BIT-1:0] genislet(input logic [VERI_BIT-1:0] kelime,
                                                     input logic [2:0] tip, input logic [1:0] ofs);
        logic [VERI_BIT-1:0] kayik;
        kayik = kelime >> {ofs, 3'b000};
        case (tip)
            3'b000:  return {{(VERI_BIT-8){kayik[7]}}, kayik[7:0]};
            3'b001:  return {{(VERI_BIT-16){kayik[15]}}, kayik[15:0]};
            3'b100:  return {{(VERI_BIT-8){1'b0}}, kayik[7:0]};
            3'b101:  return {{(VERI_BIT-16){1'b0}}, kayik[15:0]};
            default: return kayik;
        endcase
    endfunction

`ifdef HIZASIZ_ERISIM_DENETIM_EN
    function automatic logic hizasiz_mi(input logic [2:0] tip, input logic [1:0] ofs);
        case (tip)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return ofs[0];
            default:        return (ofs != 2'b00);
        endcase
    endfunction
`endif

    logic [1:0]           durum_q, durum_d;
    logic [2:0]           tip_q, tip_d;
    logic [1:0]           ofs_q, ofs_d;
    logic [4:0]           rd_q, rd_d;
    logic                 hazir_q, hazir_d;
    logic                 istek_gecerli_q, istek_gecerli_d;
    logic                 istek_yaz_q, istek_yaz_d;
    logic                 istek_oku_q, istek_oku_d;
    logic [ADRES_BIT-1:0] istek_adres_q, istek_adres_d;
    logic [3:0]           maske_q, maske_d;
    logic [VERI_BIT-1:0]  veri_q, veri_d;
    logic                 geri_gecerli_q, geri_gecerli_d;
    logic [VERI_BIT-1:0]  geri_veri_q, geri_veri_d;
    logic [4:0]           geri_rd_q, geri_rd_d;
    logic                 hizasiz_s;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
    logic                 hata_q, hata_d;
`endif

    // Misalignment detection; constant 0 when the trap is not built in.
    always_comb begin
`ifdef HIZASIZ_ERISIM_DENETIM_EN
        hizasiz_s = hizasiz_mi(bib.yurut_tip_i, bib.yurut_adres_i[1:0]);
`else
        hizasiz_s = 1'b0;
`endif
    end

    // Next-state and next-output logic of the BOSTA/BEKLE/SONUC sequencer.
    always_comb begin
        durum_d         = durum_q;
        tip_d           = tip_q;
        ofs_d           = ofs_q;
        rd_d            = rd_q;
        hazir_d         = hazir_q;
        istek_gecerli_d = istek_gecerli_q;
        istek_yaz_d     = istek_yaz_q;
        istek_oku_d     = istek_oku_q;
        istek_adres_d   = istek_adres_q;
        maske_d         = maske_q;
        veri_d          = veri_q;
        geri_gecerli_d  = geri_gecerli_q;
        geri_veri_d     = geri_veri_q;
        geri_rd_d       = geri_rd_q;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
        hata_d          = hata_q;
`endif
        case (durum_q)
            BOSTA: begin
                if (bib.yurut_gecerli_i) begin
                    tip_d   = bib.yurut_tip_i;
                    ofs_d   = bib.yurut_adres_i[1:0];
                    rd_d    = bib.yurut_rd_i;
                    hazir_d = 1'b0;
                    if (hizasiz_s) begin
                        // Trapped op never reaches the bus; report it straight to writeback.
                        durum_d        = SONUC;
                        geri_gecerli_d = 1'b1;
                        geri_veri_d    = {VERI_BIT{1'b0}};
                        geri_rd_d      = bib.yurut_rd_i;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
                        hata_d         = 1'b1;
`endif
                    end else begin
                        durum_d         = BEKLE;
                        istek_gecerli_d = 1'b1;
                        istek_yaz_d     = bib.yurut_yaz_i;
                        istek_oku_d     = ~bib.yurut_yaz_i;
                        istek_adres_d   = {bib.yurut_adres_i[ADRES_BIT-1:2], 2'b00};
                        maske_d         = maske_hesapla(bib.yurut_tip_i, bib.yurut_adres_i[1:0]);
                        veri_d          = bib.yurut_veri_i << {bib.yurut_adres_i[1:0], 3'b000};
                    end
                end else begin
                    durum_d = BOSTA;
                end
            end
            BEKLE: begin
                if (bib.bellek_gecerli_i) begin
                    istek_gecerli_d = 1'b0;
                    istek_yaz_d     = 1'b0;
                    istek_oku_d     = 1'b0;
                    if (istek_yaz_q) begin
                        durum_d = BOSTA;
                        hazir_d = 1'b1;
                    end else begin
                        durum_d        = SONUC;
                        geri_gecerli_d = 1'b1;
                        geri_veri_d    = genislet(bib.bellek_veri_i, tip_q, ofs_q);
                        geri_rd_d      = rd_q;
                    end
                end else begin
                    durum_d = BEKLE;
                end
            end
            SONUC: begin
                if (bib.geri_hazir_i) begin
                    durum_d        = BOSTA;
                    hazir_d        = 1'b1;
                    geri_gecerli_d = 1'b0;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
                    hata_d         = 1'b0;
`endif
                end else begin
                    durum_d = SONUC;
                end
            end
            default: begin
                durum_d         = BOSTA;
                hazir_d         = 1'b1;
                istek_gecerli_d = 1'b0;
                istek_yaz_d     = 1'b0;
                istek_oku_d     = 1'b0;
                geri_gecerli_d  = 1'b0;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
                hata_d          = 1'b0;
`endif
            end
        endcase
    end

    // State and all registered outputs; an outstanding request is dropped on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q         <= BOSTA;
            tip_q           <= 3'b000;
            ofs_q           <= 2'b00;
            rd_q            <= 5'd0;
            hazir_q         <= 1'b1;
            istek_gecerli_q <= 1'b0;
            istek_yaz_q     <= 1'b0;
            istek_oku_q     <= 1'b0;
            istek_adres_q   <= {ADRES_BIT{1'b0}};
            maske_q         <= 4'b0000;
            veri_q          <= {VERI_BIT{1'b0}};
            geri_gecerli_q  <= 1'b0;
            geri_veri_q     <= {VERI_BIT{1'b0}};
            geri_rd_q       <= 5'd0;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
            hata_q          <= 1'b0;
`endif
        end else begin
            durum_q         <= durum_d;
            tip_q           <= tip_d;
            ofs_q           <= ofs_d;
            rd_q            <= rd_d;
            hazir_q         <= hazir_d;
            istek_gecerli_q <= istek_gecerli_d;
            istek_yaz_q     <= istek_yaz_d;
            istek_oku_q     <= istek_oku_d;
            istek_adres_q   <= istek_adres_d;
            maske_q         <= maske_d;
            veri_q          <= veri_d;
            geri_gecerli_q  <= geri_gecerli_d;
            geri_veri_q     <= geri_veri_d;
            geri_rd_q       <= geri_rd_d;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
            hata_q          <= hata_d;
`endif
        end
    end

    assign bib.yurut_hazir_o       = hazir_q;
    assign bib.bib_istek_gecerli_o = istek_gecerli_q;
    assign bib.bib_istek_yaz_o     = istek_yaz_q;
    assign bib.bib_istek_oku_o     = istek_oku_q;
    assign bib.bib_istek_adres_o   = istek_adres_q;
    assign bib.bib_istek_maske_o   = maske_q;
    assign bib.bib_veri_o          = veri_q;
    assign bib.geri_gecerli_o      = geri_gecerli_q;
    assign bib.geri_veri_o         = geri_veri_q;
    assign bib.geri_rd_o           = geri_rd_q;
`ifdef HIZASIZ_ERISIM_DENETIM_EN
    assign bib.hata_o              = hata_q;
`endif

endmodule

// File: tb/tb_bellek_islem_birimi.sv
// Directed bench for bellek_islem_birimi; covers the misaligned trap when HIZASIZ_ERISIM_DENETIM_EN is defined.
module tb_bellek_islem_birimi;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    bellek_islem_birimi_if bif ();

    bellek_islem_birimi dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bib    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic yaz, input logic [2:0] tip, input logic [31:0] adres,
                         input logic [31:0] veri, input logic [4:0] rd);
        bif.yurut_gecerli_i = 1'b1;
        bif.yurut_yaz_i     = yaz;
        bif.yurut_tip_i     = tip;
        bif.yurut_adres_i   = adres;
        bif.yurut_veri_i    = veri;
        bif.yurut_rd_i      = rd;
        step();
        bif.yurut_gecerli_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] kelime);
        bif.bellek_gecerli_i = 1'b1;
        bif.bellek_veri_i    = kelime;
        step();
        bif.bellek_gecerli_i = 1'b0;
        bif.bellek_veri_i    = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bif.yurut_gecerli_i  = 1'b0;
        bif.yurut_yaz_i      = 1'b0;
        bif.yurut_tip_i      = 3'b000;
        bif.yurut_adres_i    = 32'h0;
        bif.yurut_veri_i     = 32'h0;
        bif.yurut_rd_i       = 5'd0;
        bif.bellek_veri_i    = 32'h0;
        bif.bellek_gecerli_i = 1'b0;
        bif.geri_hazir_i     = 1'b1;
        step();
        step();
        chk("rst_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);
        chk("rst_istek", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("rst_geri", {31'd0, bif.geri_gecerli_o}, 32'd0);
        chk("rst_maske", {28'd0, bif.bib_istek_maske_o}, 32'd0);
        chk("rst_geri_veri", bif.geri_veri_o, 32'd0);
`ifdef HIZASIZ_ERISIM_DENETIM_EN
        chk("rst_hata", {31'd0, bif.hata_o}, 32'd0);
`endif
        rstn = 1'b1;
        step();

        // LW 0x1000, response after 3 cycles
        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd5);
        chk("lw_gecerli", {31'd0, bif.bib_istek_gecerli_o}, 32'd1);
        chk("lw_oku", {31'd0, bif.bib_istek_oku_o}, 32'd1);
        chk("lw_yaz", {31'd0, bif.bib_istek_yaz_o}, 32'd0);
        chk("lw_maske", {28'd0, bif.bib_istek_maske_o}, 32'hF);
        chk("lw_adres", bif.bib_istek_adres_o, 32'h0000_1000);
        chk("lw_hazir", {31'd0, bif.yurut_hazir_o}, 32'd0);
        step();
        step();
        chk("lw_tut_gecerli", {31'd0, bif.bib_istek_gecerli_o}, 32'd1);
        chk("lw_tut_adres", bif.bib_istek_adres_o, 32'h0000_1000);
        respond(32'hDEAD_BEEF);
        chk("lw_istek_dus", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("lw_oku_dus", {31'd0, bif.bib_istek_oku_o}, 32'd0);
        chk("lw_geri_gecerli", {31'd0, bif.geri_gecerli_o}, 32'd1);
        chk("lw_geri_veri", bif.geri_veri_o, 32'hDEAD_BEEF);
        chk("lw_geri_rd", {27'd0, bif.geri_rd_o}, 32'd5);
        step();
        chk("lw_geri_bitti", {31'd0, bif.geri_gecerli_o}, 32'd0);
        chk("lw_hazir_geri", {31'd0, bif.yurut_hazir_o}, 32'd1);

        // LB / LBU 0x1003 with 0x80FFFFFF
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
        chk("lb_adres", bif.bib_istek_adres_o, 32'h0000_1000);
        chk("lb_maske", {28'd0, bif.bib_istek_maske_o}, 32'h8);
        respond(32'h80FF_FFFF);
        chk("lb_veri", bif.geri_veri_o, 32'hFFFF_FF80);
        chk("lb_rd", {27'd0, bif.geri_rd_o}, 32'd7);
        step();
        issue(1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd8);
        respond(32'h80FF_FFFF);
        chk("lbu_veri", bif.geri_veri_o, 32'h0000_0080);
        step();

        // LH sign-extension from upper half
        issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd3);
        chk("lh_maske", {28'd0, bif.bib_istek_maske_o}, 32'hC);
        respond(32'hF00D_5678);
        chk("lh_veri", bif.geri_veri_o, 32'hFFFF_F00D);
        step();

        // SH 0x2002, then back-to-back accept
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd1);
        chk("sh_maske", {28'd0, bif.bib_istek_maske_o}, 32'hC);
        chk("sh_veri", bif.bib_veri_o, 32'hABCD_0000);
        chk("sh_yaz", {31'd0, bif.bib_istek_yaz_o}, 32'd1);
        chk("sh_oku", {31'd0, bif.bib_istek_oku_o}, 32'd0);
        chk("sh_adres", bif.bib_istek_adres_o, 32'h0000_2000);
        respond(32'h0);
        chk("sh_geri_yok", {31'd0, bif.geri_gecerli_o}, 32'd0);
        chk("sh_istek_dus", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("sh_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);
        // SB 0x0001: byte lane 1
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 5'd0);
        chk("sb_maske", {28'd0, bif.bib_istek_maske_o}, 32'h2);
        chk("sb_veri", bif.bib_veri_o, 32'h0000_A500);
        respond(32'h0);

        // LHU 0x3002, writeback stalled for 5 cycles
        bif.geri_hazir_i = 1'b0;
        issue(1'b0, 3'b101, 32'h0000_3002, 32'h0, 5'd9);
        respond(32'hF00D_5678);
        for (int i = 0; i < 5; i++) begin
            chk("lhu_tut_gecerli", {31'd0, bif.geri_gecerli_o}, 32'd1);
            chk("lhu_tut_veri", bif.geri_veri_o, 32'h0000_F00D);
            chk("lhu_tut_rd", {27'd0, bif.geri_rd_o}, 32'd9);
            chk("lhu_tut_hazir", {31'd0, bif.yurut_hazir_o}, 32'd0);
            step();
        end
        bif.geri_hazir_i = 1'b1;
        chk("lhu_son_gecerli", {31'd0, bif.geri_gecerli_o}, 32'd1);
        step();
        chk("lhu_birak", {31'd0, bif.geri_gecerli_o}, 32'd0);
        chk("lhu_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);

        // Unlisted funct3 behaves as W
        issue(1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd4);
        chk("w011_maske", {28'd0, bif.bib_istek_maske_o}, 32'hF);
        respond(32'h8000_0001);
        chk("w011_veri", bif.geri_veri_o, 32'h8000_0001);
        step();

        // Reset during BEKLE, then a stray completion pulse in BOSTA
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd6);
        chk("rstb_istek", {31'd0, bif.bib_istek_gecerli_o}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rstb_istek_dus", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("rstb_oku_dus", {31'd0, bif.bib_istek_oku_o}, 32'd0);
        chk("rstb_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);
        chk("rstb_adres", bif.bib_istek_adres_o, 32'd0);
        step();
        rstn = 1'b1;
        step();
        respond(32'h1234_5678);
        chk("kacak_geri", {31'd0, bif.geri_gecerli_o}, 32'd0);
        chk("kacak_istek", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("kacak_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);
        step();
        chk("kacak_geri2", {31'd0, bif.geri_gecerli_o}, 32'd0);

        // Misaligned LW 0x1001
        issue(1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd2);
`ifdef HIZASIZ_ERISIM_DENETIM_EN
        chk("hiz_istek_yok", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("hiz_hata", {31'd0, bif.hata_o}, 32'd1);
        chk("hiz_geri", {31'd0, bif.geri_gecerli_o}, 32'd1);
        chk("hiz_veri", bif.geri_veri_o, 32'd0);
        step();
        chk("hiz_hata_temiz", {31'd0, bif.hata_o}, 32'd0);
        chk("hiz_geri_temiz", {31'd0, bif.geri_gecerli_o}, 32'd0);
        // Misaligned store is trapped as well
        issue(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1111, 5'd0);
        chk("hiz_sh_istek_yok", {31'd0, bif.bib_istek_gecerli_o}, 32'd0);
        chk("hiz_sh_hata", {31'd0, bif.hata_o}, 32'd1);
        step();
`else
        chk("hiz_istek", {31'd0, bif.bib_istek_gecerli_o}, 32'd1);
        chk("hiz_maske", {28'd0, bif.bib_istek_maske_o}, 32'hE);
        respond(32'hAABB_CCDD);
        chk("hiz_veri", bif.geri_veri_o, 32'h00AA_BBCC);
        step();
`endif
        chk("son_hazir", {31'd0, bif.yurut_hazir_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
